// File: rtl/definitions_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : definitions_pkg
// Description : Shared image geometry, FSM state encoding and 3x3 window type
//               for the Gaussian window controller.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions_pkg;

    localparam int IMAGE_WIDTH  = 512;
    localparam int IMAGE_HEIGHT = 512;
    localparam int PIXEL_W      = 8;
    localparam int COORD_W      = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Index 8 is the top-left pixel, index 0 the bottom-right pixel.
    typedef logic [8:0][7:0] window_t;

endpackage : definitions_pkg
`default_nettype wire

// File: rtl/gaussian_window_ctrl_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Single-port line memory, one entry per column. The read port
//               is combinational, so a write at the same address returns the
//               previous line's value in that cycle (read-before-write).
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int DEPTH  = definitions_pkg::IMAGE_WIDTH,
    parameter int DATA_W = definitions_pkg::PIXEL_W,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    // Contents are fully rewritten during priming, so no reset is needed.
    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rd_data = r_mem[i_addr];

    // Store the incoming pixel at its column address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule : line_buffer
`default_nettype wire

// File: rtl/gaussian_window_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gaussian_window_ctrl
// Description : Accepts a raster-order grayscale frame and emits every interior
//               3x3 neighbourhood with its centre coordinate, using two line
//               buffers and a 3x3 shift register. Borders produce no windows.
// Revision    : 1.0 - initial release
// ============================================================================
module gaussian_window_ctrl #(
    parameter int IMAGE_WIDTH  = definitions_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = definitions_pkg::IMAGE_HEIGHT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    output logic        in_ready,
    output logic        out_valid,
    output logic [71:0] out_window,
    output logic [8:0]  out_x,
    output logic [8:0]  out_y,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done
);

    import definitions_pkg::*;

    localparam int         c_AW        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [8:0] c_LAST_COL  = 9'(IMAGE_WIDTH - 1);
    localparam logic [8:0] c_LAST_ROW  = 9'(IMAGE_HEIGHT - 1);
    localparam logic [8:0] c_LAST_X    = 9'(IMAGE_WIDTH - 2);
    localparam logic [8:0] c_LAST_Y    = 9'(IMAGE_HEIGHT - 2);

    localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [1:0] c_ST_PRIME  = ST_PRIME;
    localparam logic [1:0] c_ST_ACTIVE = ST_ACTIVE;
    localparam logic [1:0] c_ST_DONE   = ST_DONE;

    logic [1:0] r_state;
    logic [8:0] r_col;
    logic [8:0] r_row;
    window_t    r_win;
    window_t    w_win_next;
    window_t    r_out_win;
    logic       r_out_valid;
    logic [8:0] r_out_x;
    logic [8:0] r_out_y;
    logic [7:0] w_lb0_rd;
    logic [7:0] w_lb1_rd;
    logic       w_accept;
    logic       w_emit;
    logic       w_last_hs;

    assign busy       = (r_state != c_ST_IDLE);
    assign frame_done = (r_state == c_ST_DONE);
    assign in_ready   = busy && (r_state != c_ST_DONE) && (!r_out_valid || out_ready);

    assign w_accept   = in_valid && in_ready;
    // Only interior centres: the pixel just accepted is the bottom-right corner.
    assign w_emit     = w_accept && (r_row >= 9'd2) && (r_col >= 9'd2);
    assign w_last_hs  = r_out_valid && out_ready && (r_out_x == c_LAST_X) && (r_out_y == c_LAST_Y);

    // Shift left by one column; new right column is {line r-2, line r-1, pixel}.
    assign w_win_next = {r_win[7], r_win[6], w_lb1_rd,
                         r_win[4], r_win[3], w_lb0_rd,
                         r_win[1], r_win[0], in_pixel};

    assign out_valid  = r_out_valid;
    assign out_window = r_out_win;
    assign out_x      = r_out_x;
    assign out_y      = r_out_y;

    // lb0 holds the previous line, lb1 the line before; lb0's old value cascades into lb1.
    line_buffer #(.DEPTH(IMAGE_WIDTH), .DATA_W(8), .ADDR_W(c_AW)) u_lb0 (
        .clk       (clk),
        .i_we      (w_accept),
        .i_addr    (r_col[c_AW-1:0]),
        .i_wr_data (in_pixel),
        .o_rd_data (w_lb0_rd)
    );

    line_buffer #(.DEPTH(IMAGE_WIDTH), .DATA_W(8), .ADDR_W(c_AW)) u_lb1 (
        .clk       (clk),
        .i_we      (w_accept),
        .i_addr    (r_col[c_AW-1:0]),
        .i_wr_data (w_lb0_rd),
        .o_rd_data (w_lb1_rd)
    );

    // Frame sequencing: prime two lines plus two pixels, stream, then pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:   if (start) r_state <= c_ST_PRIME;
                c_ST_PRIME:  if (w_accept && (r_row == 9'd2) && (r_col == 9'd1)) r_state <= c_ST_ACTIVE;
                c_ST_ACTIVE: if (w_last_hs) r_state <= c_ST_DONE;
                c_ST_DONE:   r_state <= c_ST_IDLE;
                default:     r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Raster position of the next pixel to be accepted; parked at zero while idle.
    always_ff @(posedge clk) begin
        if (rst || (r_state == c_ST_IDLE)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == c_LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST_ROW) ? 9'd0 : r_row + 9'd1;
            end else begin
                r_col <= r_col + 9'd1;
            end
        end
    end

    // The 3x3 shift register advances only on an accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_accept) begin
            r_win <= w_win_next;
        end
    end

    // Output register: loads on emission, holds under back-pressure, clears on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_win   <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_win   <= w_win_next;
            r_out_x     <= r_col - 9'd1;
            r_out_y     <= r_row - 9'd1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule : gaussian_window_ctrl
`default_nettype wire

// File: tb/tb_gaussian_window_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gaussian_window_ctrl
// Description : Scoreboard bench for gaussian_window_ctrl on a reduced 8x6
//               frame: ramp and hashed images, back-pressure, input gaps,
//               stray start pulses and a mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gaussian_window_ctrl;

    localparam int c_W    = 8;
    localparam int c_H    = 6;
    localparam int c_NWIN = (c_W - 2) * (c_H - 2);

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_pixel;
    logic        in_ready;
    logic        out_valid;
    logic [71:0] out_window;
    logic [8:0]  out_x;
    logic [8:0]  out_y;
    logic        out_ready;
    logic        busy;
    logic        frame_done;

    typedef struct {
        logic [71:0] win;
        logic [8:0]  x;
        logic [8:0]  y;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [7:0] img [c_H][c_W];
    int         n_cmp     = 0;
    int         n_bad     = 0;
    int         win_count = 0;
    int         rdy_mode  = 0;

    gaussian_window_ctrl #(.IMAGE_WIDTH(c_W), .IMAGE_HEIGHT(c_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_window (out_window),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        if (pat == 0) return 8'((r + c) % 256);
        return 8'((r * 37 + c * 11 + 5) % 256);
    endfunction

    task automatic fill(input int pat);
        for (int r = 0; r < c_H; r++)
            for (int c = 0; c < c_W; c++)
                img[r][c] = pix(pat, r, c);
    endtask

    // Drive one pixel until accepted; push the window it completes.
    task automatic send_pixel(input int r, input int c);
        int   b;
        exp_t e;
        in_valid = 1'b1;
        in_pixel = img[r][c];
        b = 0;
        @(negedge clk);
        while (!in_ready && b < 1000) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) begin
            fail_now("pixel_accept");
        end else if (r >= 2 && c >= 2) begin
            e.win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                     img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                     img[r][c-2],   img[r][c-1],   img[r][c]};
            e.x = 9'(c - 1);
            e.y = 9'(r - 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Stream pixels up to and including (stop_row, 0); stop_row < 0 sends the whole frame.
    task automatic send_frame(input int pat, input bit gaps, input bit starts, input int stop_row);
        fill(pat);
        for (int r = 0; r < c_H; r++) begin
            for (int c = 0; c < c_W; c++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    in_pixel = 8'($urandom);
                    repeat ($urandom_range(1, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                if (starts && ((r == 3 && c == 4) || (r == 4 && c == 0))) start = 1'b1;
                send_pixel(r, c);
                start = 1'b0;
                if (r == stop_row && c == 0) begin
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        @(negedge clk);
        while (!frame_done && b < 1000) begin
            @(negedge clk);
            b++;
        end
        check("frame_done_seen", 72'(frame_done), 72'd1);
        @(negedge clk);
        check("frame_done_one_cycle", 72'(frame_done), 72'd0);
        check("busy_after_done", 72'(busy), 72'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"},  72'(out_valid),  72'd0);
        check({tag, "_busy"},       72'(busy),       72'd0);
        check({tag, "_frame_done"}, 72'(frame_done), 72'd0);
        check({tag, "_in_ready"},   72'(in_ready),   72'd0);
        check({tag, "_out_window"}, out_window,      72'd0);
        check({tag, "_out_x"},      72'(out_x),      72'd0);
        check({tag, "_out_y"},      72'(out_y),      72'd0);
    endtask

    // Monitor: compare every handshaken window against the scoreboard and audit frame ends.
    always @(negedge clk) begin
        if (rst) begin
            win_count = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_window");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("window", out_window, mon_e.win);
                    check("centre_x", 72'(out_x), 72'(mon_e.x));
                    check("centre_y", 72'(out_y), 72'(mon_e.y));
                    win_count++;
                end
            end
            if (frame_done) begin
                check("frame_queue_empty", 72'(exp_q.size()), 72'd0);
                check("frame_window_count", 72'(win_count), 72'(c_NWIN));
                win_count = 0;
            end
        end
    end

    // Downstream ready generator; mode 2 stalls on the first window and verifies the hold.
    initial begin
        int b;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b0;
                b = 0;
                @(negedge clk);
                while (!out_valid && b < 1000) begin
                    @(negedge clk);
                    b++;
                end
                if (!out_valid) begin
                    fail_now("stall_first_window");
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        @(posedge clk);
                        @(negedge clk);
                        check("stall_in_ready", 72'(in_ready), 72'd0);
                        check("stall_out_valid", 72'(out_valid), 72'd1);
                        if (exp_q.size() > 0) begin
                            check("stall_window", out_window, exp_q[0].win);
                            check("stall_x", 72'(out_x), 72'(exp_q[0].x));
                        end
                    end
                end
                rdy_mode = 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pixel = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Pixels offered while idle must be ignored.
        in_valid = 1'b1;
        in_pixel = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", 72'(in_ready), 72'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        // Frame 1: ramp image, always ready.
        rdy_mode = 0;
        begin_frame();
        send_frame(0, 1'b0, 1'b0, -1);
        wait_done();

        // Frame 2: hashed image, initial stall, random ready, input gaps, stray starts.
        rdy_mode = 2;
        begin_frame();
        send_frame(1, 1'b1, 1'b1, -1);
        wait_done();

        // Frame 3: aborted by reset at row 3.
        rdy_mode = 0;
        begin_frame();
        send_frame(0, 1'b0, 1'b0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("abort");
        check("abort_queue_empty", 72'(exp_q.size()), 72'd0);
        exp_q.delete();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("abort_no_output", 72'(out_valid), 72'd0);

        // Frame 4: full ramp frame after the abort.
        begin_frame();
        send_frame(0, 1'b0, 1'b0, -1);
        wait_done();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_gaussian_window_ctrl
`default_nettype wire

// File: doc/gaussian_window_ctrl.md
GAUSSIAN_WINDOW_CTRL -- requirements
Module: gaussian_window_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default definitions_pkg::IMAGE_WIDTH (512), pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default definitions_pkg::IMAGE_HEIGHT (512), lines per frame.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-007 in_valid  input  1  in_pixel holds a valid pixel.
REQ-008 in_pixel  input  8  raster-order grayscale pixel.
REQ-009 in_ready  output  1  block can accept a pixel this cycle.
REQ-010 out_valid  output  1  out_window holds a valid 3x3 window.
REQ-011 out_window  output  72  row-major 3x3 window; [71:64] top-left, [7:0] bottom-right; top row is the oldest line.
REQ-012 out_x / out_y  output  9 each  column/row of the window centre.
REQ-013 out_ready  input  1  downstream convolver accepts the window.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after the final window handshake.

Function
REQ-016 FSM states SHALL be IDLE, PRIME, ACTIVE and DONE.
REQ-017 IDLE->PRIME on start; in IDLE, in_ready=0.
REQ-018 PRIME SHALL accept lines 0-1 and pixels 0-1 of line 2 with no output.
REQ-019 PRIME->ACTIVE SHALL occur on acceptance of pixel (row 2, col 1).
REQ-020 ACTIVE->DONE SHALL occur on handshake of the window centred at (IMAGE_WIDTH-2, IMAGE_HEIGHT-2).
REQ-021 DONE SHALL pulse frame_done for one cycle and then return to IDLE.
REQ-022 A pixel is accepted when in_valid && in_ready; in_ready = busy && state!=DONE && (!out_valid || out_ready).
REQ-023 Column counter SHALL run 0..IMAGE_WIDTH-1 and wrap to 0 with a row increment; row counter SHALL run 0..IMAGE_HEIGHT-1.
REQ-024 Acceptance of pixel (r,c) with r>=2 and c>=2 SHALL register the window centred at (r-1,c-1) with out_valid=1 on the next cycle (latency 1).
REQ-025 Borders SHALL emit no windows; exactly (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) windows per frame.
REQ-026 out_window/out_x/out_y SHALL hold stable while out_valid && !out_ready.
REQ-027 Simultaneous window handshake and new acceptance SHALL replace the output register without a bubble.
REQ-028 Window shift registers SHALL shift only on acceptance; line buffers SHALL be read-before-write at the column address.
REQ-029 start outside IDLE SHALL be ignored; in_valid while in_ready=0 SHALL have no effect.

Reset
REQ-030 On rst: state=IDLE and counters=0; out_valid, busy, frame_done and in_ready=0; out_window, out_x and out_y=0.
REQ-031 rst SHALL override all other inputs in the same cycle and abort a frame mid-operation without emitting further windows.
REQ-032 Line-buffer contents SHALL need no reset; PRIME overwrites them before use.

Structure
REQ-033 definitions_pkg SHALL gain IMAGE_HEIGHT, the state enum typedef, and a window typedef (logic [8:0][7:0] packed).
REQ-034 One sub-module, line_buffer (depth IMAGE_WIDTH, 8-bit, single-port read-before-write), SHALL be instantiated twice.

Verification
REQ-035 Ramp frame with pixel=(r+c) mod 256 and out_ready=1 -> first window at centre (1,1) = 0,1,2,1,2,3,2,3,4.
REQ-036 Full 512x512 frame -> exactly 260100 windows, last centre (510,510), then frame_done high for one cycle and busy=0.
REQ-037 Hold out_ready=0 after the first window -> in_ready=0 next cycle and the window is held; release -> no loss or duplication.
REQ-038 Assert rst at row 100 -> all outputs 0 next cycle; a new start yields the first window again at centre (1,1).
REQ-039 Pulse start mid-frame and toggle in_valid randomly -> no change in window sequence or count.
